// File: rtl/adc_twin_pkg.sv
// adc_twin_pkg
//   Constants and FSM encoding shared by the ADC capture stage and the twin
//   comparator. BUF_W is the packed buffer width (sample k at [12k+11:12k]).
package adc_twin_pkg;

  localparam int SAMPLE_W    = 12;
  localparam int NUM_SAMPLES = 10;
  localparam int BUF_W       = SAMPLE_W * NUM_SAMPLES;
  localparam int SUM_W       = SAMPLE_W + 4;
  localparam int IDX_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/twin_sample_diff.sv
// twin_sample_diff
//   Combinational absolute difference of one ADC sample against its twin,
//   plus the mismatch flag (strictly greater than threshold).
//   a, b       : samples to compare
//   threshold  : largest |a-b| still treated as a match
//   d          : |a-b|
//   mismatch   : d > threshold
module twin_sample_diff
  import adc_twin_pkg::*;
(
  input  logic [SAMPLE_W-1:0] a,
  input  logic [SAMPLE_W-1:0] b,
  input  logic [SAMPLE_W-1:0] threshold,
  output logic [SAMPLE_W-1:0] d,
  output logic                mismatch
);

  logic [SAMPLE_W:0] diff_w;

  always_comb begin
    // One extra bit so the borrow tells us which operand is larger.
    diff_w = {1'b0, a} - {1'b0, b};
    if (diff_w[SAMPLE_W]) begin
      d = b - a;
    end else begin
      d = diff_w[SAMPLE_W-1:0];
    end
    mismatch = (d > threshold);
  end

endmodule

// File: rtl/adc_twin_compare.sv
// adc_twin_compare
//   On start (IDLE only) snapshots the ADC capture buffer, the twin buffer and
//   the threshold, then compares one sample per cycle, oldest (k=NUM_SAMPLES-1)
//   first. Reports |diff| statistics and a failure verdict.
//   Handshake: start is a request sampled only in IDLE; busy is high while
//   samples are being compared; done is a one-cycle pulse marking the result
//   outputs valid. Results hold until the next accepted start.
//   clk, rst (async, active-low), start, storage, twin, threshold  : inputs
//   busy, done, fail, fail_index, max_diff, sum_diff, mismatch_cnt : results
//   dbg_state : current FSM state (adc_twin_pkg::state_t encoding)
module adc_twin_compare
  import adc_twin_pkg::*;
#(
  parameter int FAIL_RUN = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BUF_W-1:0]    storage,
  input  logic [BUF_W-1:0]    twin,
  input  logic [SAMPLE_W-1:0] threshold,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic [IDX_W-1:0]    fail_index,
  output logic [SAMPLE_W-1:0] max_diff,
  output logic [SUM_W-1:0]    sum_diff,
  output logic [IDX_W-1:0]    mismatch_cnt,
  output logic [1:0]          dbg_state
);

  localparam int RUN_W = $clog2(FAIL_RUN + 1);

  state_t              state_q, state_d;
  logic [BUF_W-1:0]    snap_s_q, snap_t_q;
  logic [SAMPLE_W-1:0] thr_q;
  logic [IDX_W-1:0]    idx_q;
  logic [RUN_W-1:0]    run_q;

  logic [SAMPLE_W-1:0] cur_s, cur_t, cur_d;
  logic                cur_mis;
  logic                run_hits;

  assign cur_s = snap_s_q[int'(idx_q)*SAMPLE_W +: SAMPLE_W];
  assign cur_t = snap_t_q[int'(idx_q)*SAMPLE_W +: SAMPLE_W];

  twin_sample_diff u_diff (
    .a         (cur_s),
    .b         (cur_t),
    .threshold (thr_q),
    .d         (cur_d),
    .mismatch  (cur_mis)
  );

  // This mismatch brings the run to FAIL_RUN (run saturates there, and fail
  // is already set by then, so later runs cannot move fail_index).
  assign run_hits = cur_mis && (int'(run_q) >= FAIL_RUN - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CMP;
      ST_CMP:  if (idx_q == '0) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_s_q     <= '0;
      snap_t_q     <= '0;
      thr_q        <= '0;
      idx_q        <= '0;
      run_q        <= '0;
      fail         <= 1'b0;
      fail_index   <= '0;
      max_diff     <= '0;
      sum_diff     <= '0;
      mismatch_cnt <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            snap_s_q     <= storage;
            snap_t_q     <= twin;
            thr_q        <= threshold;
            idx_q        <= IDX_W'(NUM_SAMPLES - 1);
            run_q        <= '0;
            fail         <= 1'b0;
            fail_index   <= '0;
            max_diff     <= '0;
            sum_diff     <= '0;
            mismatch_cnt <= '0;
          end
        end
        ST_CMP: begin
          sum_diff <= sum_diff + SUM_W'(cur_d);
          if (cur_d > max_diff) max_diff <= cur_d;
          if (cur_mis) begin
            mismatch_cnt <= mismatch_cnt + 1'b1;
            if (int'(run_q) < FAIL_RUN) run_q <= run_q + 1'b1;
            if (run_hits && !fail) begin
              fail       <= 1'b1;
              fail_index <= idx_q;
            end
          end else begin
            run_q <= '0;
          end
          if (idx_q != '0) idx_q <= idx_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q == ST_CMP);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_adc_twin_compare.sv
// tb_adc_twin_compare
//   Directed and randomized compares of adc_twin_compare against a
//   sample-array reference model with a queue of expected results.
module tb_adc_twin_compare;
  import adc_twin_pkg::*;

  localparam int FAIL_RUN = 2;
  localparam int EXP_W    = 1 + IDX_W + SAMPLE_W + SUM_W + IDX_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  logic                start = 1'b0;
  logic [BUF_W-1:0]    storage = '0;
  logic [BUF_W-1:0]    twin = '0;
  logic [SAMPLE_W-1:0] threshold = '0;
  logic                busy, done, fail;
  logic [IDX_W-1:0]    fail_index, mismatch_cnt;
  logic [SAMPLE_W-1:0] max_diff;
  logic [SUM_W-1:0]    sum_diff;
  logic [1:0]          dbg_state;

  adc_twin_compare #(.FAIL_RUN(FAIL_RUN)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .storage      (storage),
    .twin         (twin),
    .threshold    (threshold),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .fail_index   (fail_index),
    .max_diff     (max_diff),
    .sum_diff     (sum_diff),
    .mismatch_cnt (mismatch_cnt),
    .dbg_state    (dbg_state)
  );

  // scoreboard
  logic [EXP_W-1:0]    exp_q[$];
  logic [SAMPLE_W-1:0] s_arr[NUM_SAMPLES];
  logic [SAMPLE_W-1:0] t_arr[NUM_SAMPLES];
  logic [SAMPLE_W-1:0] thr_v;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference: walk samples oldest first with plain integer arithmetic.
  task automatic model_push();
    int d, sum, mx, cnt, run, fidx;
    bit f;
    sum = 0; mx = 0; cnt = 0; run = 0; fidx = 0; f = 1'b0;
    for (int k = NUM_SAMPLES - 1; k >= 0; k--) begin
      d = int'(s_arr[k]) - int'(t_arr[k]);
      if (d < 0) d = -d;
      sum += d;
      if (d > mx) mx = d;
      if (d > int'(thr_v)) begin
        cnt++;
        run++;
        if (run == FAIL_RUN && !f) begin
          f = 1'b1;
          fidx = k;
        end
      end else begin
        run = 0;
      end
    end
    exp_q.push_back({f, IDX_W'(fidx), SAMPLE_W'(mx), SUM_W'(sum), IDX_W'(cnt)});
  endtask

  task automatic apply_inputs();
    for (int k = 0; k < NUM_SAMPLES; k++) begin
      storage[k*SAMPLE_W +: SAMPLE_W] = s_arr[k];
      twin[k*SAMPLE_W +: SAMPLE_W]    = t_arr[k];
    end
    threshold = thr_v;
  endtask

  task automatic check_results(input string tag, input logic [EXP_W-1:0] e);
    check({tag, ".fail"},       32'(fail),         32'(e[EXP_W-1]));
    check({tag, ".fail_index"}, 32'(fail_index),   32'(e[EXP_W-2 -: IDX_W]));
    check({tag, ".max_diff"},   32'(max_diff),     32'(e[IDX_W+SUM_W +: SAMPLE_W]));
    check({tag, ".sum_diff"},   32'(sum_diff),     32'(e[IDX_W +: SUM_W]));
    check({tag, ".mis_cnt"},    32'(mismatch_cnt), 32'(e[IDX_W-1:0]));
  endtask

  // driver: one full compare; disturb re-pulses start and scrambles inputs mid-compare
  task automatic run_compare(input string tag, input bit disturb);
    int lat, busy_cnt, extra_done;
    bit got_done;
    logic [EXP_W-1:0] e;
    apply_inputs();
    model_push();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy_start"}, 32'(busy), 32'd1);
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    got_done = 1'b0;
    while (!got_done && lat < 30) begin
      if (disturb && lat == 2) begin
        start     = 1'b1;
        storage   = {4{$urandom()}};
        twin      = {4{$urandom()}};
        threshold = SAMPLE_W'($urandom_range(0, 4095));
      end
      if (disturb && lat == 3) start = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (done) got_done = 1'b1;
      else if (busy) busy_cnt++;
    end
    check({tag, ".done_lat"}, 32'(lat), 32'(NUM_SAMPLES));
    check({tag, ".busy_cyc"}, 32'(busy_cnt), 32'(NUM_SAMPLES));
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    check({tag, ".state_done"}, 32'(dbg_state), 32'(ST_DONE));
    if (exp_q.size() == 0) begin
      check({tag, ".exp_empty"}, 32'd1, 32'd0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check_results(tag, e);
    extra_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    check({tag, ".extra_done"}, 32'(extra_done), 32'd0);
    check_results({tag, ".hold"}, e);
  endtask

  task automatic fill_equal(input logic [SAMPLE_W-1:0] v);
    for (int k = 0; k < NUM_SAMPLES; k++) begin
      s_arr[k] = v;
      t_arr[k] = v;
    end
  endtask

  initial begin
    int base;
    // reset state
    #15;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.state", 32'(dbg_state), 32'(ST_IDLE));
    check_results("rst", '0);
    @(negedge clk);
    rst = 1'b1;

    // 1: identical buffers, threshold 0
    fill_equal(12'h400);
    thr_v = 12'd0;
    run_compare("t1_equal", 1'b0);

    // 2: every sample off by 5, threshold 4
    for (int k = 0; k < NUM_SAMPLES; k++) begin
      s_arr[k] = 12'd5;
      t_arr[k] = 12'd0;
    end
    thr_v = 12'd4;
    run_compare("t2_all_mis", 1'b0);

    // 3: single mismatch at k=3
    fill_equal(SAMPLE_W'($urandom_range(0, 3000)));
    s_arr[3] = t_arr[3] + 12'd100;
    thr_v = 12'd10;
    run_compare("t3_single", 1'b0);

    // 4: run ends exactly at k=0; diff == threshold elsewhere
    for (int k = 0; k < NUM_SAMPLES; k++) begin
      t_arr[k] = SAMPLE_W'($urandom_range(100, 4000));
      s_arr[k] = t_arr[k] - 12'd19;
    end
    s_arr[1] = t_arr[1] - 12'd20;
    s_arr[0] = t_arr[0] - 12'd20;
    thr_v = 12'd19;
    run_compare("t4_run_k0", 1'b0);

    // full-scale differences
    for (int k = 0; k < NUM_SAMPLES; k++) begin
      s_arr[k] = 12'hFFF;
      t_arr[k] = 12'h000;
    end
    thr_v = 12'hFFE;
    run_compare("t_fullscale", 1'b0);

    // 5: start re-pulsed and inputs changed mid-compare
    for (int k = 0; k < NUM_SAMPLES; k++) begin
      t_arr[k] = SAMPLE_W'($urandom_range(0, 4095));
      s_arr[k] = SAMPLE_W'($urandom_range(0, 4095));
    end
    thr_v = SAMPLE_W'($urandom_range(0, 2000));
    run_compare("t5_disturb", 1'b1);

    // 6: reset during the 4th compare cycle
    fill_equal(12'h123);
    s_arr[9] = 12'h000;
    s_arr[8] = 12'h000;
    thr_v = 12'd1;
    apply_inputs();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #5;
    rst = 1'b0;
    #1;
    check("t6.busy", 32'(busy), 32'd0);
    check("t6.done", 32'(done), 32'd0);
    check("t6.state", 32'(dbg_state), 32'(ST_IDLE));
    check_results("t6", '0);
    begin
      int seen_done;
      seen_done = 0;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        if (done) seen_done++;
      end
      check("t6.no_done", 32'(seen_done), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    run_compare("t6_after", 1'b0);

    // randomized compares with near-threshold differences
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < NUM_SAMPLES; k++) begin
        t_arr[k] = SAMPLE_W'($urandom_range(0, 4095));
        if ($urandom_range(0, 7) == 0) begin
          s_arr[k] = SAMPLE_W'($urandom_range(0, 4095));
        end else begin
          base = int'(t_arr[k]) + $urandom_range(0, 80) - 40;
          if (base < 0) base = 0;
          if (base > 4095) base = 4095;
          s_arr[k] = SAMPLE_W'(base);
        end
      end
      case ($urandom_range(0, 4))
        0:       thr_v = 12'd0;
        1:       thr_v = 12'hFFF;
        default: thr_v = SAMPLE_W'($urandom_range(0, 40));
      endcase
      run_compare($sformatf("rnd%0d", it), it % 7 == 3);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
